mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. Consumes the execute-stage pipeline register outputs, runs load/store accesses on a single-outstanding req/ready data-memory port with wait-state support and a timeout, aligns and extends load data, selects the write-back value, and registers it into the MEM/WB pipeline register. While an access waits, it stalls the pipeline.

---
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_stage.sv | 99 +++++++++
 tb/tb_mem_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: single-outstanding req/ready data-memory port
// master (pipeline side) drives dm_req/dm_we/dm_addr/dm_wstrb/dm_wdata and
// samples dm_ready/dm_rdata; slave (memory side) is the mirror image.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  modport master(output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, input dm_ready, dm_rdata);
  modport slave(input dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, output dm_ready, dm_rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage feeding the MEM/WB register
// clk/rst: clock and async active-high reset; EXE_*: execute-stage register
// outputs; dm: data-memory port (master); mem_stall: freeze upstream;
// mem_err: misaligned/timeout pulse; MEM_*: MEM/WB register outputs.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        EXE_pc_to_reg,
  input  logic [31:0]        EXE_ALU_out,
  input  logic [31:0]        EXE_rs2_data,
  input  logic [4:0]         EXE_rd_addr,
  input  logic [2:0]         EXE_funct3,
  input  logic               EXE_RDSrc,
  input  logic               EXE_MemtoReg,
  input  logic               EXE_MemWrite,
  input  logic               EXE_MemRead,
  input  logic               EXE_RegWrite,
  mem_stage_if.master        dm,
  output logic               mem_stall,
  output logic               mem_err,
  output logic [31:0]        MEM_rd_data,
  output logic [4:0]         MEM_rd_addr,
  output logic               MEM_RegWrite
);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        regwrite_q, regwrite_d;
  logic        err_q, err_d;
  logic [1:0]  off;
  logic        mem_op, misal, pending, abort;
  logic [31:0] lane, ld_data;
  always_comb begin
    off = EXE_ALU_out[1:0];
    mem_op = EXE_MemRead | EXE_MemWrite;
    misal = (EXE_funct3[1:0] == 2'b01 & off[0]) | (EXE_funct3[1:0] == 2'b10 & |off);
    pending = mem_op & ~misal;
    // cnt_q counts wait cycles already spent with the request up; the cycle
    // after TIMEOUT such cycles drops the request and aborts
    abort = state_q == WAIT & ~dm.dm_ready & cnt_q == TO;
    // gated by rst so the request vanishes the moment reset asserts
    dm.dm_req = ~rst & (state_q == WAIT | pending) & ~abort;
    dm.dm_we = dm.dm_req & EXE_MemWrite;
    dm.dm_addr = {EXE_ALU_out[31:2], 2'b00};
    dm.dm_wstrb = ~dm.dm_we ? 4'b0000 :
                  EXE_funct3[1:0] == 2'b00 ? 4'b0001 << off :
                  EXE_funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    dm.dm_wdata = EXE_funct3[1:0] == 2'b00 ? {4{EXE_rs2_data[7:0]}} :
                  EXE_funct3[1:0] == 2'b01 ? {2{EXE_rs2_data[15:0]}} : EXE_rs2_data;
    mem_stall = dm.dm_req & ~dm.dm_ready;
    lane = dm.dm_rdata >> {off, 3'b000};
    ld_data = EXE_funct3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
              EXE_funct3 == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
              EXE_funct3 == 3'b100 ? {24'b0, lane[7:0]} :
              EXE_funct3 == 3'b101 ? {16'b0, lane[15:0]} : dm.dm_rdata;
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      state_d = mem_stall ? WAIT : IDLE;
      cnt_d = 8'd0;
    end else if (dm.dm_ready | abort) begin
      state_d = IDLE;
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    err_d = (mem_op & misal) | abort;
    rd_data_d = mem_stall ? rd_data_q : EXE_MemtoReg ? ld_data : EXE_RDSrc ? EXE_pc_to_reg : EXE_ALU_out;
    rd_addr_d = mem_stall ? rd_addr_q : EXE_rd_addr;
    // stalled cycles insert a bubble; failed accesses never write back
    regwrite_d = ~mem_stall & EXE_RegWrite & ~(mem_op & misal) & ~abort;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      rd_data_q <= 32'd0;
      rd_addr_q <= 5'd0;
      regwrite_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
      regwrite_q <= regwrite_d;
      err_q <= err_d;
    end
  end
  assign MEM_rd_data = rd_data_q;
  assign MEM_rd_addr = rd_addr_q;
  assign MEM_RegWrite = regwrite_q;
  assign mem_err = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a transaction-level model
module tb_mem_stage;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_stage_if dm();
  logic [31:0] pc = '0, alu = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  f3 = '0;
  logic rdsrc = 0, m2r = 0, mw = 0, mr = 0, rw = 0;
  logic [31:0] mem_rd_data;
  logic [4:0]  mem_rd_addr;
  logic mem_regwrite, mem_stall, mem_err;
  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .EXE_pc_to_reg(pc), .EXE_ALU_out(alu), .EXE_rs2_data(rs2),
    .EXE_rd_addr(rd), .EXE_funct3(f3),
    .EXE_RDSrc(rdsrc), .EXE_MemtoReg(m2r), .EXE_MemWrite(mw), .EXE_MemRead(mr), .EXE_RegWrite(rw),
    .dm(dm),
    .mem_stall(mem_stall), .mem_err(mem_err),
    .MEM_rd_data(mem_rd_data), .MEM_rd_addr(mem_rd_addr), .MEM_RegWrite(mem_regwrite)
  );
  int tests = 0, fails = 0, stall_cnt = 0, req_cnt = 0;
  logic chk_on = 1'b1;
  logic e_req = 0, e_stall = 0, e_we = 0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_wstrb = '0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_addr = '0;
  logic m_rw = 0, m_err = 0;
  function automatic void check(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction
  function automatic logic [31:0] ld_model(logic [2:0] f, logic [31:0] d, logic [1:0] off);
    logic [31:0] w;
    w = d >> (8 * off);
    case (f)
      3'b000: return {{24{w[7]}}, w[7:0]};
      3'b001: return {{16{w[15]}}, w[15:0]};
      3'b100: return {24'b0, w[7:0]};
      3'b101: return {16'b0, w[15:0]};
      default: return d;
    endcase
  endfunction
  function automatic logic [3:0] st_strb(logic [2:0] f, logic [1:0] off);
    int sz;
    logic [3:0] s;
    sz = 1 << f[1:0];
    for (int b = 0; b < 4; b++) s[b] = (b >= int'(off)) && (b < int'(off) + sz);
    return s;
  endfunction
  function automatic logic [31:0] st_data(logic [2:0] f, logic [31:0] d);
    int sz;
    logic [31:0] r;
    sz = 1 << f[1:0];
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % sz) +: 8];
    return r;
  endfunction
  function automatic bit misal(logic [2:0] f, logic [31:0] a);
    return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a[1:0] != 2'b00);
  endfunction
  always @(negedge clk) if (chk_on) begin
    if (mem_stall) stall_cnt++;
    if (dm.dm_req) req_cnt++;
    check("dm_req", dm.dm_req, e_req);
    check("mem_stall", mem_stall, e_stall);
    if (e_req) begin
      check("dm_addr", dm.dm_addr, e_addr);
      check("dm_we", dm.dm_we, e_we);
      check("dm_wstrb", dm.dm_wstrb, e_wstrb);
      if (e_we) check("dm_wdata", dm.dm_wdata, e_wdata);
    end
    check("MEM_RegWrite", mem_regwrite, m_rw);
    check("MEM_rd_addr", mem_rd_addr, m_addr);
    check("MEM_rd_data", mem_rd_data, m_data);
    check("mem_err", mem_err, m_err);
  end
  // one instruction; lat = cycle index (0 = issue cycle) on which memory answers
  task automatic run(input logic [2:0] f, input logic wr, input logic rdq, input logic tr,
                     input logic rs, input logic rwi, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] p, input logic [4:0] r, input int lat, input logic [31:0] rdv);
    bit mem, mis, acc, ab, last;
    logic [31:0] cur;
    mem = wr | rdq;
    mis = misal(f, a);
    acc = mem && !mis;
    f3 = f; mw = wr; mr = rdq; m2r = tr; rdsrc = rs; rw = rwi; alu = a; rs2 = d; pc = p; rd = r;
    e_addr = {a[31:2], 2'b00};
    e_we = wr;
    e_wstrb = wr ? st_strb(f, a[1:0]) : 4'b0000;
    e_wdata = st_data(f, d);
    for (int k = 0; k <= TO + 1; k++) begin
      cur = (k == lat) ? rdv : $urandom;
      dm.dm_rdata = cur;
      dm.dm_ready = acc ? (k == lat) : 1'($urandom_range(0, 1));
      ab = acc && k == TO + 1 && lat > TO + 1;
      e_req = acc && !ab;
      e_stall = e_req && k != lat;
      last = !acc || k == lat || ab;
      @(posedge clk);
      #1;
      if (!last) begin
        m_rw = 0;
        m_err = 0;
      end else begin
        m_addr = r;
        m_rw = rwi && !(mem && mis) && !ab;
        m_err = (mem && mis) || ab;
        m_data = tr ? ld_model(f, cur, a[1:0]) : rs ? p : a;
        break;
      end
    end
  endtask
  initial begin
    dm.dm_ready = 0;
    dm.dm_rdata = '0;
    check("lit_lb", ld_model(3'b000, 32'h0080_0000, 2'd2), 32'hFFFF_FF80);
    check("lit_lbu", ld_model(3'b100, 32'h0080_0000, 2'd2), 32'h0000_0080);
    check("lit_sb_strb", st_strb(3'b000, 2'd3), 4'b1000);
    check("lit_sb_data", st_data(3'b000, 32'h0000_00AB), 32'hABAB_ABAB);
    check("lit_sh_strb", st_strb(3'b001, 2'd2), 4'b1100);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    run(3'b000, 0, 0, 0, 0, 1, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 32'h0);
    check("alu_model", m_data, 32'h1234);
    run(3'b000, 1, 0, 0, 0, 0, 32'h103, 32'hAB, 32'h0, 5'd1, 0, 32'h0);
    stall_cnt = 0;
    req_cnt = 0;
    run(3'b000, 0, 1, 1, 0, 1, 32'h102, 32'h0, 32'h0, 5'd7, 3, 32'h0080_0000);
    check("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    check("lb_model", m_data, 32'hFFFF_FF80);
    run(3'b100, 0, 1, 1, 0, 1, 32'h102, 32'h0, 32'h0, 5'd8, 3, 32'h0080_0000);
    check("lbu_model", m_data, 32'h0000_0080);
    run(3'b010, 0, 1, 1, 0, 1, 32'h102, 32'h0, 32'h0, 5'd9, 0, 32'h0);
    check("misal_err_model", 32'(m_err), 32'd1);
    req_cnt = 0;
    run(3'b010, 0, 1, 1, 0, 1, 32'h200, 32'h0, 32'h0, 5'd10, 99, 32'h0);
    check("timeout_req_cycles", 32'(req_cnt), 32'(TO + 1));
    run(3'b000, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'hCAFE_0004, 5'd11, 0, 32'h0);
    chk_on = 0;
    f3 = 3'b010; mr = 1; mw = 0; m2r = 1; rw = 1; alu = 32'h300; rd = 5'd12;
    dm.dm_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst_dm_req", dm.dm_req, 1'b0);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_rd_data", mem_rd_data, 32'h0);
    check("rst_rd_addr", mem_rd_addr, 5'd0);
    check("rst_regwrite", mem_regwrite, 1'b0);
    check("rst_err", mem_err, 1'b0);
    @(posedge clk);
    #1 rst = 0;
    m_data = '0; m_addr = '0; m_rw = 0; m_err = 0;
    chk_on = 1;
    run(3'b010, 0, 1, 1, 0, 1, 32'h304, 32'h0, 32'h0, 5'd13, 1, 32'h1357_9BDF);
    for (int i = 0; i < 400; i++) begin
      int kind, lat;
      logic wr, rdq;
      logic [2:0] f;
      kind = $urandom_range(0, 3);
      wr = kind == 2 || kind == 3;
      rdq = kind == 1 || kind == 3;
      f = wr ? 3'($urandom_range(0, 2)) : 3'($urandom);
      lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 3) : $urandom_range(0, 2);
      run(f, wr, rdq, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          5'($urandom), lat, $urandom);
    end
    e_req = 0;
    e_stall = 0;
    mr = 0; mw = 0;
    @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
